// File: rtl/io_bus_bridge.sv
// Bridge from the CPU's one-hot IO port to the peripherals and the hardware-config block.
// Latches each access, checks that the address is one-hot, drives registered selects and handles wait-state timeouts.
module io_bus_bridge #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [19:0] cpu_addr,
    input  logic        cpu_rstrb,
    input  logic        cpu_wstrb,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_busy,
    output logic        cpu_err,
    output logic [16:0] dev_sel,
    output logic        dev_rd,
    output logic        dev_wr,
    output logic [31:0] dev_wdata,
    input  logic [31:0] dev_rdata,
    input  logic        dev_busy,
    output logic        hw_sel_memory,
    output logic        hw_sel_devices,
    output logic        hw_sel_cpuinfo,
    input  logic [31:0] hw_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WAIT,
        ST_ERR
    } state_t;

    localparam logic [CNT_WIDTH-1:0] TIMEOUT_VAL = CNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

    state_t                state_reg, state_next;
    logic [19:0]           addr_reg, addr_next;
    logic                  write_reg, write_next;
    logic [CNT_WIDTH-1:0]  cnt_reg, cnt_next;
    logic [31:0]           rdata_reg, rdata_next;
    logic [31:0]           wdata_reg, wdata_next;
    logic                  busy_reg, busy_next;
    logic                  err_reg, err_next;
    logic [16:0]           dev_sel_reg, dev_sel_next;
    logic                  dev_rd_reg, dev_rd_next;
    logic                  dev_wr_reg, dev_wr_next;
    logic [2:0]            hw_sel_reg, hw_sel_next;
    logic                  is_cfg;

    assign is_cfg = |addr_reg[19:17];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg   <= ST_IDLE;
            addr_reg    <= '0;
            write_reg   <= 1'b0;
            cnt_reg     <= '0;
            rdata_reg   <= '0;
            wdata_reg   <= '0;
            busy_reg    <= 1'b0;
            err_reg     <= 1'b0;
            dev_sel_reg <= '0;
            dev_rd_reg  <= 1'b0;
            dev_wr_reg  <= 1'b0;
            hw_sel_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            addr_reg    <= addr_next;
            write_reg   <= write_next;
            cnt_reg     <= cnt_next;
            rdata_reg   <= rdata_next;
            wdata_reg   <= wdata_next;
            busy_reg    <= busy_next;
            err_reg     <= err_next;
            dev_sel_reg <= dev_sel_next;
            dev_rd_reg  <= dev_rd_next;
            dev_wr_reg  <= dev_wr_next;
            hw_sel_reg  <= hw_sel_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        write_next = write_reg;
        wdata_next = wdata_reg;
        cnt_next   = cnt_reg;
        rdata_next = rdata_reg;

        case (state_reg)
            ST_IDLE: begin
                if (cpu_rstrb || cpu_wstrb) begin
                    addr_next  = cpu_addr;
                    wdata_next = cpu_wdata;
                    write_next = cpu_wstrb && !cpu_rstrb;
                    if ((cpu_rstrb && cpu_wstrb) || !$onehot(cpu_addr))
                        state_next = ST_ERR;
                    else
                        state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // Config block never stalls, so dev_busy only matters for peripherals.
                if (is_cfg || !dev_busy) begin
                    state_next = ST_IDLE;
                    if (!write_reg)
                        rdata_next = is_cfg ? hw_rdata : dev_rdata;
                end else begin
                    state_next = ST_WAIT;
                    cnt_next   = CNT_ONE;
                end
            end
            ST_WAIT: begin
                if (!dev_busy) begin
                    state_next = ST_IDLE;
                    if (!write_reg)
                        rdata_next = dev_rdata;
                end else if (cnt_reg == TIMEOUT_VAL) begin
                    state_next = ST_ERR;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            ST_ERR: begin
                state_next = ST_IDLE;
                if (!write_reg)
                    rdata_next = '0;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every select and strobe comes straight from a flop.
    always_comb begin
        busy_next    = (state_next != ST_IDLE);
        err_next     = (state_next == ST_ERR);
        dev_sel_next = '0;
        dev_rd_next  = 1'b0;
        dev_wr_next  = 1'b0;
        hw_sel_next  = '0;
        if (state_next == ST_ACCESS || state_next == ST_WAIT)
            dev_sel_next = addr_next[16:0];
        if (state_next == ST_ACCESS) begin
            hw_sel_next = addr_next[19:17];
            dev_rd_next = (|addr_next[16:0]) && !write_next;
            dev_wr_next = (|addr_next[16:0]) && write_next;
        end
    end

    assign cpu_rdata      = rdata_reg;
    assign cpu_busy       = busy_reg;
    assign cpu_err        = err_reg;
    assign dev_sel        = dev_sel_reg;
    assign dev_rd         = dev_rd_reg;
    assign dev_wr         = dev_wr_reg;
    assign dev_wdata      = wdata_reg;
    assign hw_sel_memory  = hw_sel_reg[0];
    assign hw_sel_devices = hw_sel_reg[1];
    assign hw_sel_cpuinfo = hw_sel_reg[2];

endmodule

// File: tb/tb_io_bus_bridge.sv
// Directed testbench for io_bus_bridge: config and peripheral accesses, wait states,
// timeout, illegal addresses and asynchronous reset in the middle of an access.
module tb_io_bus_bridge;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [19:0] cpu_addr = '0;
    logic        cpu_rstrb = 1'b0;
    logic        cpu_wstrb = 1'b0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_busy;
    logic        cpu_err;
    logic [16:0] dev_sel;
    logic        dev_rd;
    logic        dev_wr;
    logic [31:0] dev_wdata;
    logic [31:0] dev_rdata;
    logic        dev_busy = 1'b0;
    logic        hw_sel_memory;
    logic        hw_sel_devices;
    logic        hw_sel_cpuinfo;
    logic [31:0] hw_rdata;

    int checks_cnt = 0;
    int errors_cnt = 0;

    always #5 clk = ~clk;

    // Simple peripheral and config-block models: read data depends on which select is live.
    assign dev_rdata = dev_sel[1] ? 32'h0000_0041 : (dev_sel[8] ? 32'h0000_0088 : 32'h0);
    assign hw_rdata  = hw_sel_memory  ? 32'h0000_8000 :
                       hw_sel_devices ? 32'h0010_0007 :
                       hw_sel_cpuinfo ? 32'hC0DE_0001 : 32'h0;

    io_bus_bridge #(
        .TIMEOUT_CYCLES(4),
        .CNT_WIDTH(16)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .cpu_addr(cpu_addr),
        .cpu_rstrb(cpu_rstrb),
        .cpu_wstrb(cpu_wstrb),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .cpu_busy(cpu_busy),
        .cpu_err(cpu_err),
        .dev_sel(dev_sel),
        .dev_rd(dev_rd),
        .dev_wr(dev_wr),
        .dev_wdata(dev_wdata),
        .dev_rdata(dev_rdata),
        .dev_busy(dev_busy),
        .hw_sel_memory(hw_sel_memory),
        .hw_sel_devices(hw_sel_devices),
        .hw_sel_cpuinfo(hw_sel_cpuinfo),
        .hw_rdata(hw_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] hw_sel_vec();
        return {hw_sel_cpuinfo, hw_sel_devices, hw_sel_memory};
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_rdata"}, cpu_rdata, 32'h0);
        check({tag, "_busy"}, {31'h0, cpu_busy}, 32'h0);
        check({tag, "_err"}, {31'h0, cpu_err}, 32'h0);
        check({tag, "_dev_sel"}, {15'h0, dev_sel}, 32'h0);
        check({tag, "_dev_rdwr"}, {30'h0, dev_rd, dev_wr}, 32'h0);
        check({tag, "_dev_wdata"}, dev_wdata, 32'h0);
        check({tag, "_hw_sel"}, {29'h0, hw_sel_vec()}, 32'h0);
    endtask

    task automatic issue(input logic [19:0] addr, input logic rd, input logic wr, input logic [31:0] wd);
        cpu_addr  = addr;
        cpu_rstrb = rd;
        cpu_wstrb = wr;
        cpu_wdata = wd;
        step();
        cpu_rstrb = 1'b0;
        cpu_wstrb = 1'b0;
    endtask

    initial begin
        #2;
        check_all_zero("reset");
        step();
        check_all_zero("reset_held");
        resetn = 1'b1;

        // Config read of the device mask
        issue(20'h1 << 18, 1'b1, 1'b0, 32'h0);
        check("cfg_busy", {31'h0, cpu_busy}, 32'h1);
        check("cfg_hw_sel", {29'h0, hw_sel_vec()}, 32'h2);
        check("cfg_dev_sel", {15'h0, dev_sel}, 32'h0);
        check("cfg_err", {31'h0, cpu_err}, 32'h0);
        step();
        check("cfg_hw_sel_drop", {29'h0, hw_sel_vec()}, 32'h0);
        check("cfg_busy_drop", {31'h0, cpu_busy}, 32'h0);
        check("cfg_rdata", cpu_rdata, 32'h0010_0007);
        check("cfg_err2", {31'h0, cpu_err}, 32'h0);
        $display("TXN cfg read devices rdata=%h", cpu_rdata);

        // LED write, back-to-back with the previous read; strobe left high while busy
        cpu_addr  = 20'h1;
        cpu_wdata = 32'hA;
        cpu_wstrb = 1'b1;
        step();
        cpu_addr  = 20'h1 << 2;
        check("led_dev_sel", {15'h0, dev_sel}, 32'h1);
        check("led_dev_wr", {30'h0, dev_rd, dev_wr}, 32'h1);
        check("led_wdata", dev_wdata, 32'hA);
        check("led_busy", {31'h0, cpu_busy}, 32'h1);
        step();
        cpu_wstrb = 1'b0;
        check("led_dev_sel_drop", {15'h0, dev_sel}, 32'h0);
        check("led_dev_wr_drop", {30'h0, dev_rd, dev_wr}, 32'h0);
        check("led_busy_drop", {31'h0, cpu_busy}, 32'h0);
        check("led_rdata_kept", cpu_rdata, 32'h0010_0007);
        step();
        check("busy_strobe_ignored", {15'h0, dev_sel}, 32'h0);
        check("busy_strobe_ignored_busy", {31'h0, cpu_busy}, 32'h0);
        $display("TXN led write wdata=%h", dev_wdata);

        // UART read with three stall cycles
        issue(20'h1 << 1, 1'b1, 1'b0, 32'h0);
        dev_busy = 1'b1;
        check("uart_dev_sel", {15'h0, dev_sel}, 32'h2);
        check("uart_dev_rd", {30'h0, dev_rd, dev_wr}, 32'h2);
        step();
        check("uart_wait1_sel", {15'h0, dev_sel}, 32'h2);
        check("uart_wait1_rd", {30'h0, dev_rd, dev_wr}, 32'h0);
        step();
        check("uart_wait2_sel", {15'h0, dev_sel}, 32'h2);
        step();
        dev_busy = 1'b0;
        check("uart_wait3_sel", {15'h0, dev_sel}, 32'h2);
        check("uart_wait3_busy", {31'h0, cpu_busy}, 32'h1);
        step();
        check("uart_sel_drop", {15'h0, dev_sel}, 32'h0);
        check("uart_busy_drop", {31'h0, cpu_busy}, 32'h0);
        check("uart_rdata", cpu_rdata, 32'h41);
        check("uart_err", {31'h0, cpu_err}, 32'h0);
        $display("TXN uart read rdata=%h", cpu_rdata);

        // Timeout on a stuck bit-8 peripheral
        issue(20'h1 << 8, 1'b1, 1'b0, 32'h0);
        dev_busy = 1'b1;
        check("to_access_sel", {15'h0, dev_sel}, 32'h100);
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("to_wait%0d_sel", i + 1), {15'h0, dev_sel}, 32'h100);
            check($sformatf("to_wait%0d_err", i + 1), {31'h0, cpu_err}, 32'h0);
        end
        step();
        check("to_err", {31'h0, cpu_err}, 32'h1);
        check("to_err_busy", {31'h0, cpu_busy}, 32'h1);
        check("to_err_sel", {15'h0, dev_sel}, 32'h0);
        dev_busy = 1'b0;
        step();
        check("to_err_drop", {31'h0, cpu_err}, 32'h0);
        check("to_busy_drop", {31'h0, cpu_busy}, 32'h0);
        check("to_rdata", cpu_rdata, 32'h0);
        $display("TXN timeout read bit8 rdata=%h", cpu_rdata);

        issue(20'h1 << 17, 1'b1, 1'b0, 32'h0);
        check("mem_hw_sel", {29'h0, hw_sel_vec()}, 32'h1);
        step();
        check("mem_rdata", cpu_rdata, 32'h0000_8000);
        $display("TXN cfg read memory rdata=%h", cpu_rdata);

        // Illegal addresses separated by a valid read
        issue(20'h00003, 1'b1, 1'b0, 32'h0);
        check("ill3_err", {31'h0, cpu_err}, 32'h1);
        check("ill3_busy", {31'h0, cpu_busy}, 32'h1);
        check("ill3_dev_sel", {15'h0, dev_sel}, 32'h0);
        check("ill3_hw_sel", {29'h0, hw_sel_vec()}, 32'h0);
        step();
        check("ill3_err_drop", {31'h0, cpu_err}, 32'h0);
        check("ill3_rdata", cpu_rdata, 32'h0);
        $display("TXN illegal read addr=00003 rdata=%h", cpu_rdata);
        issue(20'h1 << 19, 1'b1, 1'b0, 32'h0);
        step();
        check("cpuinfo_rdata", cpu_rdata, 32'hC0DE_0001);
        $display("TXN cfg read cpuinfo rdata=%h", cpu_rdata);
        issue(20'h0, 1'b1, 1'b0, 32'h0);
        check("ill0_err", {31'h0, cpu_err}, 32'h1);
        check("ill0_dev_sel", {15'h0, dev_sel}, 32'h0);
        step();
        check("ill0_err_drop", {31'h0, cpu_err}, 32'h0);
        check("ill0_rdata", cpu_rdata, 32'h0);
        $display("TXN illegal read addr=00000 rdata=%h", cpu_rdata);

        // Config write completes without error
        issue(20'h1 << 18, 1'b0, 1'b1, 32'h1234);
        check("cfgwr_err", {31'h0, cpu_err}, 32'h0);
        check("cfgwr_hw_sel", {29'h0, hw_sel_vec()}, 32'h2);
        step();
        check("cfgwr_rdata", cpu_rdata, 32'h0);
        $display("TXN cfg write devices");

        // Reset asserted mid-WAIT, no clock edge in between
        issue(20'h1 << 1, 1'b1, 1'b0, 32'h0);
        dev_busy = 1'b1;
        step();
        check("rst_pre_sel", {15'h0, dev_sel}, 32'h2);
        #2;
        resetn = 1'b0;
        #1;
        check_all_zero("rst_async");
        step();
        dev_busy = 1'b0;
        resetn = 1'b1;
        check_all_zero("rst_released");
        issue(20'h1 << 1, 1'b1, 1'b0, 32'h0);
        check("post_rst_sel", {15'h0, dev_sel}, 32'h2);
        step();
        check("post_rst_rdata", cpu_rdata, 32'h41);
        check("post_rst_busy", {31'h0, cpu_busy}, 32'h0);
        $display("TXN post-reset uart read rdata=%h", cpu_rdata);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/io_bus_bridge.md
Name: io_bus_bridge

Overview:
- Sits between the CPU's one-hot IO port and the IO peripherals, including the hardware-config register block.
- Latches each CPU IO read or write and checks that its address is one-hot.
- Drives a registered one-hot select, either to a peripheral (bits 0..16) or to the config block (bits 17..19 as sel_memory/sel_devices/sel_cpuinfo).
- Handles peripheral wait states with a timeout and returns registered read data plus busy/error to the CPU.

Parameters:
- TIMEOUT_CYCLES, 255: maximum number of WAIT cycles before the access is aborted with an error; range 1..65535.
- CNT_WIDTH, 16: width of the wait counter; must satisfy 2^CNT_WIDTH > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- cpu_addr  in  20  one-hot IO word address (bit n = IO register n).
- cpu_rstrb  in  1  single-cycle read request.
- cpu_wstrb  in  1  single-cycle write request.
- cpu_wdata  in  32  write data, sampled with cpu_wstrb.
- cpu_rdata  out  32  registered read data.
- cpu_busy  out  1  access in progress.
- cpu_err  out  1  one-cycle pulse marking an access that completed with an error.
- dev_sel  out  17  one-hot peripheral select (bits 0..16).
- dev_rd  out  1  read pulse to the selected peripheral.
- dev_wr  out  1  write pulse to the selected peripheral.
- dev_wdata  out  32  latched write data.
- dev_rdata  in  32  OR-combined peripheral read data.
- dev_busy  in  1  selected peripheral stall.
- hw_sel_memory  out  1  config RAM-size select (address bit 17).
- hw_sel_devices  out  1  config device-mask select (address bit 18).
- hw_sel_cpuinfo  out  1  config CPU-info select (address bit 19).
- hw_rdata  in  32  config block read data (combinational from the selects).

Behaviour:
- Reset (asynchronous, immediate):
  - State = IDLE.
  - cpu_rdata = 0, cpu_busy = 0, cpu_err = 0.
  - dev_sel = 0, dev_rd = 0, dev_wr = 0, dev_wdata = 0, all hw_sel_* = 0, wait counter = 0.
  - Reset asserted mid-access aborts the access; no completion and no error pulse is produced.
- States: IDLE, ACCESS, WAIT, ERR.
- IDLE: cpu_busy = 0, no selects asserted. On an edge with cpu_rstrb or cpu_wstrb high:
  - Latch cpu_addr, cpu_wdata and direction.
  - cpu_rstrb and cpu_wstrb both high, or cpu_addr not exactly one bit set (0 or ≥2 bits) → ERR.
  - Otherwise → ACCESS.
- ACCESS (exactly one cycle):
  - cpu_busy = 1.
  - Latched bit 0..16: dev_sel[bit] = 1 and dev_rd or dev_wr = 1.
  - Latched bit 17..19: the matching hw_sel_* = 1; dev_* stay 0.
  - At the edge ending ACCESS:
    - Config target, or peripheral with dev_busy = 0 → complete.
    - Peripheral with dev_busy = 1 → WAIT, counter cleared to 1.
- WAIT:
  - dev_sel stays held; dev_rd/dev_wr = 0; cpu_busy = 1.
  - Each edge with dev_busy = 1 increments the counter.
  - dev_busy = 0 → complete.
  - Counter == TIMEOUT_CYCLES with dev_busy still 1 → ERR.
- Complete: next state IDLE.
  - A read loads cpu_rdata from dev_rdata (peripheral) or hw_rdata (config).
  - A write leaves cpu_rdata unchanged.
  - All selects drop in the same edge.
- ERR (exactly one cycle):
  - cpu_busy = 1, cpu_err = 1, no selects asserted.
  - A read loads cpu_rdata = 0.
  - Writes to config bits 17..19 are not errors: they complete from ACCESS with no side effect.
  - Next state IDLE.
- Latency, strobe sampled at edge E0:
  - Zero-wait access: cpu_busy high for the one cycle after E0; cpu_rdata valid and cpu_busy low after E0+2.
  - Each dev_busy cycle adds one cycle.
  - Error: cpu_busy and cpu_err high for the one cycle after E0; cpu_busy low after E0+2.
- Strobes arriving while cpu_busy = 1 are ignored.
- A new strobe in the same cycle busy falls (state IDLE) is accepted normally, allowing back-to-back accesses every 2 cycles.
- Selects are registered outputs: glitch-free, and at most one of dev_sel/hw_sel_* is high at any time.

Test Plan:
- Read config, cpu_addr = 1<<18, cpu_rstrb pulse, hw_rdata = 32'h0010_0007 → hw_sel_devices high for exactly 1 cycle; cpu_rdata = 32'h0010_0007 two cycles after the strobe; cpu_err never high.
- Write LEDs, cpu_addr = 1<<0, cpu_wdata = 32'hA, dev_busy = 0 → dev_sel = 17'h1, dev_wr = 1 and dev_wdata = 32'hA for one cycle; cpu_rdata unchanged.
- UART read, cpu_addr = 1<<1, dev_busy high for 3 cycles after select, dev_rdata = 32'h41 → dev_sel[1] held 4 cycles; dev_rd pulses once; cpu_rdata = 32'h41; cpu_busy low 5 cycles after the strobe.
- Illegal address 20'h00003, then 20'h0 → two separate cpu_err pulses; no select ever asserted; cpu_rdata = 0 after each read.
- Timeout, TIMEOUT_CYCLES = 4, dev_busy stuck at 1 on a bit-8 read → cpu_err pulse after 4 WAIT cycles; dev_sel returns to 0; cpu_rdata = 0; the following bit-17 read returns hw_rdata correctly.
- Deassert resetn during WAIT → all outputs 0 with no clock edge needed; after release, state is IDLE and a fresh read completes normally.
